// File: rtl/regfile_dump_if.sv
// regfile_dump_if
//   Bundles the register-file read port and the outbound word stream used by
//   the register-file dumper.
//
//   rf_addr   : register-file read address (driven by the dumper)
//   rf_data   : combinational read data for rf_addr (x0 reads as 0)
//   out_valid : stream word valid
//   out_ready : sink accepts the current word
//   out_data  : stream word
//   out_last  : marks the final (checksum) word
//
//   master : dumper side
//   slave  : register file / sink side
interface regfile_dump_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [WIDTH-1:0]      rf_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;

  modport master (
    output rf_addr,
    input  rf_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  rf_addr,
    output rf_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/regfile_dump.sv
// regfile_dump
//   Debug reader for the integer register file. On start it reads x0 up to
//   x(NUM_REGS-1) one at a time, streams each value over a valid/ready
//   interface and closes the stream with a modulo-2^WIDTH checksum word.
//   While busy is high the core is stalled and the read-port address mux
//   selects rf_addr.
//
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset; aborts a dump in progress
//   start : dump request, only honoured while idle (never queued)
//   bus   : read port + output stream (see regfile_dump_if)
//   busy  : high in every state except idle
//   done  : one-cycle pulse in the first idle cycle after the checksum
//           word has been accepted
module regfile_dump #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  regfile_dump_if.master bus,
  output logic           busy,
  output logic           done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    CSUM = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0]      sum_reg, sum_next;
  logic [WIDTH-1:0]      data_reg, data_next;
  logic                  done_reg, done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      sum_reg   <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      sum_reg   <= sum_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    sum_next      = sum_reg;
    data_next     = data_reg;
    done_next     = 1'b0;
    bus.rf_addr   = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          idx_next   = '0;
          sum_next   = '0;
          state_next = READ;
        end
      end

      READ: begin
        // Capture the word so it stays stable under backpressure even if
        // the read-port mux changes; the checksum drops the carry.
        bus.rf_addr = idx_reg;
        data_next   = bus.rf_data;
        sum_next    = sum_reg + bus.rf_data;
        state_next  = SEND;
      end

      SEND: begin
        bus.rf_addr   = idx_reg;
        bus.out_valid = 1'b1;
        bus.out_data  = data_reg;
        if (bus.out_ready) begin
          // idx stops at the last register; it never wraps to x0.
          if (idx_reg == LAST_IDX) begin
            state_next = CSUM;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = READ;
          end
        end
      end

      CSUM: begin
        bus.rf_addr   = idx_reg;
        bus.out_valid = 1'b1;
        bus.out_data  = sum_reg;
        bus.out_last  = 1'b1;
        if (bus.out_ready) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // done is registered, so it lands in the first idle cycle and can never
  // coincide with busy.
  assign busy = (state_reg != IDLE);
  assign done = done_reg;

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  localparam int W = 32;
  localparam int AW = 5;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  logic busy, done;

  logic [W-1:0] regs [N];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] words [$];
  logic         lasts [$];
  int           dones;
  int           busy_cyc;

  regfile_dump_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  regfile_dump #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_REGS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done)
  );

  // Register file: combinational read, x0 hard-wired to zero.
  assign bus.rf_data   = (bus.rf_addr == '0) ? '0 : regs[bus.rf_addr];
  assign bus.out_ready = ready;

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one dump and compares the stream against a reference built from the
  // register contents: every register value in order (x0 forced to 0), then
  // their 32-bit wrapped total with out_last set.
  task automatic run_dump(input bit do_start, input int mode, input bit spam,
                          input int hold_idx, input int abort_idx, input bit restart,
                          input int exp_busy, output bit aborted);
    logic [W-1:0] exp_w [$];
    logic [W-1:0] acc;
    logic [W-1:0] v;
    int hold_left;
    int first_valid;
    bit finished;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      v = (i == 0) ? '0 : regs[i];
      exp_w.push_back(v);
      acc = acc + v;
    end
    exp_w.push_back(acc);

    words.delete();
    lasts.delete();
    dones = 0;
    busy_cyc = 0;
    hold_left = 5;
    first_valid = -1;
    finished = 0;
    aborted = 0;

    if (do_start) begin
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
    end

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (abort_idx >= 0 && bus.out_valid && words.size() == abort_idx) begin
        chk("abort_word", bus.out_data, exp_w[abort_idx]);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", W'(busy), '0);
        chk("abort_valid", W'(bus.out_valid), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_last", W'(bus.out_last), '0);
        chk("abort_addr", W'(bus.rf_addr), '0);
        @(posedge clk); #1;
        chk("abort_done2", W'(done), '0);
        chk("abort_busy2", W'(busy), '0);
        aborted = 1;
        return;
      end
      start = done ? restart : (spam ? 1'($urandom_range(0, 1)) : 1'b0);
      if (hold_idx >= 0 && bus.out_valid && words.size() == hold_idx && hold_left > 0) begin
        ready = 1'b0;
        hold_left--;
      end else if (mode == 1) begin
        ready = 1'($urandom_range(0, 1));
      end else begin
        ready = 1'b1;
      end

      @(negedge clk);
      if (done) begin
        dones++;
        chk("done_not_busy", W'(busy), '0);
        finished = 1;
      end
      if (busy) busy_cyc++;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (!ready && hold_idx >= 0 && words.size() == hold_idx) begin
        chk("hold_valid", W'(bus.out_valid), 1);
        chk("hold_data", bus.out_data, exp_w[hold_idx]);
        chk("hold_last", W'(bus.out_last), '0);
      end
      if (bus.out_valid && ready) begin
        if (!bus.out_last) chk("rf_addr", W'(bus.rf_addr), W'(words.size()));
        words.push_back(bus.out_data);
        lasts.push_back(bus.out_last);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    ready = 1'b1;

    if (!finished) chk("dump_timeout", 0, 1);
    chk("word_count", W'(words.size()), W'(N + 1));
    for (int i = 0; i < words.size() && i <= N; i++) begin
      chk($sformatf("word%0d", i), words[i], exp_w[i]);
      chk($sformatf("last%0d", i), W'(lasts[i]), W'(i == N));
    end
    chk("done_count", W'(dones), 1);
    chk("first_valid_cycle", W'(first_valid), 1);
    if (exp_busy >= 0) chk("busy_span", W'(busy_cyc), W'(exp_busy));
    $display("dump: words=%0d csum=%0h dones=%0d busy=%0d", words.size(),
             (words.size() > N) ? words[N] : '0, dones, busy_cyc);
  endtask

  initial begin
    bit ab;
    for (int i = 0; i < N; i++) regs[i] = W'(3 * i);

    // Reset with random inputs.
    for (int k = 0; k < 3; k++) begin
      start = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    chk("rst_valid", W'(bus.out_valid), '0);
    chk("rst_last", W'(bus.out_last), '0);
    chk("rst_data", bus.out_data, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_addr", W'(bus.rf_addr), '0);
    rst = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_done", W'(done), '0);
    $display("reset: checks=%0d errors=%0d", checks, errors);

    // Basic dump x_i = 3i.
    run_dump(1, 0, 0, -1, -1, 0, 65, ab);
    if (words.size() > N) chk("csum_1488", words[N], 32'd1488);

    // Backpressure on x4 for 5 cycles.
    run_dump(1, 0, 0, 4, -1, 0, 70, ab);
    if (words.size() > N) chk("bp_csum_1488", words[N], 32'd1488);

    // Checksum wrap.
    for (int i = 0; i < N; i++) regs[i] = 32'hFFFF_FFFF;
    run_dump(1, 0, 0, -1, -1, 0, 65, ab);
    if (words.size() > N) chk("csum_wrap", words[N], 32'hFFFF_FFE1);

    // Ignored starts, then a start in the done cycle.
    for (int i = 0; i < N; i++) regs[i] = W'(3 * i);
    run_dump(1, 0, 1, -1, -1, 1, 65, ab);
    run_dump(0, 0, 0, -1, -1, 0, 65, ab);
    if (words.size() > 0) chk("restart_x0", words[0], '0);

    // Reset mid-dump while x10 is valid, then a fresh dump.
    run_dump(1, 0, 0, -1, 10, 0, -1, ab);
    chk("aborted", W'(ab), 1);
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    run_dump(1, 0, 0, -1, -1, 0, 65, ab);

    // Random data, random backpressure, random start spam.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) regs[i] = $urandom;
      run_dump(1, 1, 1, -1, -1, 0, -1, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
